// File: rtl/xyz_capture_fifo.sv
// xyz_capture_fifo
// Captures {x,y,z} result triples from the upstream datapath into a small
// synchronous FIFO and presents the head entry over a valid/ready handshake.
// Triples arriving while the buffer is full and not draining are dropped and
// flagged through the sticky overflow bit.
//
// Build option:
//   XYZ_FIFO_DROP_CNT_EN - adds drop_cnt[7:0], a saturating count of dropped
//                          triples, cleared by ovf_clr.

module xyz_capture_fifo #(
    parameter int DW    = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    input  logic [DW-1:0] z,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_x,
    output logic [DW-1:0] out_y,
    output logic [DW-1:0] out_z,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr
`ifdef XYZ_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]    drop_cnt
`endif
);

    localparam int          TW       = 3 * DW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [TW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;
    logic [TW-1:0] head;

    // Status flags, handshake qualifiers and the combinational head read.
    // A push into a full FIFO is allowed when the head leaves in the same cycle.
    always_comb begin
        empty     = (count == '0);
        full      = (count == FULL_CNT);
        out_valid = !empty;
        pop       = out_valid && out_ready;
        push      = in_valid && (!full || pop);
        drop      = in_valid && full && !pop;
        head      = mem[rd_ptr];
        out_x     = head[3*DW-1:2*DW];
        out_y     = head[2*DW-1:DW];
        out_z     = head[DW-1:0];
    end

    // Storage: written at wr_ptr on push, cleared on reset so out_* read zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= {x, y, z};
        end
    end

    // Read/write pointers; DEPTH is a power of two so they wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: unchanged when a push and a pop coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as ovf_clr keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef XYZ_FIFO_DROP_CNT_EN
    // Saturating drop counter; clear plus drop in one cycle leaves exactly one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (ovf_clr) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (ovf_clr) begin
            drop_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_xyz_capture_fifo.sv
// Bench for xyz_capture_fifo: queue-based reference model checked every
// falling edge, plus directed scenarios with hand-computed expectations.

module tb_xyz_capture_fifo;

    typedef logic [11:0] trip_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] x, y, z;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_x, out_y, out_z;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       ovf_clr;
`ifdef XYZ_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    trip_t q[$];
    trip_t popped[$];
    trip_t want[$];
    bit    m_ovf;
    int    m_drop;
    bit    m_pop, m_push, m_drp;

    xyz_capture_fifo #(.DW(4), .DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
`ifdef XYZ_FIFO_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue of triples with sticky drop tracking.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            m_pop  = (q.size() != 0) && out_ready;
            m_push = in_valid && (q.size() < 4 || m_pop);
            m_drp  = in_valid && (q.size() == 4) && !m_pop;
            if (m_pop) popped.push_back(q.pop_front());
            if (m_push) q.push_back({x, y, z});
            if (m_drp) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (m_drp) m_drop = ovf_clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
            else if (ovf_clr) m_drop = 0;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("count",     32'(count),     32'(q.size()));
        chk("full",      32'(full),      32'(q.size() == 4));
        chk("empty",     32'(empty),     32'(q.size() == 0));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        if (q.size() != 0) chk("head", 32'({out_x, out_y, out_z}), 32'(q[0]));
`ifdef XYZ_FIFO_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    end

    task automatic cyc(input logic iv, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic rdy, input logic clr);
        in_valid  = iv;
        x         = a;
        y         = b;
        z         = c;
        out_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string nm);
        chk({nm, "_len"}, 32'(popped.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < popped.size(); i++) begin
            chk(nm, 32'(popped[i]), 32'(want[i]));
        end
        popped.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; z = '0;
        out_ready = 1'b0; ovf_clr = 1'b0;
        #1 rst = 1'b0;

        // Reset held with in_valid asserted
        cyc(1, 4'hF, 4'hE, 4'hD, 0, 0);
        cyc(1, 4'hF, 4'hE, 4'hD, 0, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'({out_x, out_y, out_z}), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);

        // Ordering
        popped.delete();
        cyc(1, 3, 5, 8, 0, 0);
        cyc(1, 1, 2, 3, 0, 0);
        cyc(1, 7, 7, 7, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("ord_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
        chk("ord_empty", 32'(empty), 32'd1);
        want = '{12'h358, 12'h123, 12'h777};
        chk_log("ord_pop");

        // Full and drop
        for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 4'(i), 4'(i), 0, 0);
        chk("full_set", 32'(full), 32'd1);
        chk("full_ovf0", 32'(overflow), 32'd0);
        cyc(1, 5, 5, 5, 0, 0);
        chk("drop_ovf",   32'(overflow), 32'd1);
        chk("drop_count", 32'(count), 32'd4);
        chk("drop_head",  32'({out_x, out_y, out_z}), 32'h111);
`ifdef XYZ_FIFO_DROP_CNT_EN
        chk("drop_cnt1", 32'(drop_cnt), 32'd1);
`endif
        // Drop together with clear: drop wins
        cyc(1, 8, 8, 8, 0, 1);
        chk("dropclr_ovf", 32'(overflow), 32'd1);
`ifdef XYZ_FIFO_DROP_CNT_EN
        chk("dropclr_cnt", 32'(drop_cnt), 32'd1);
`endif
        // Full pass-through
        cyc(1, 6, 6, 6, 1, 0);
        chk("pass_count", 32'(count), 32'd4);
        chk("pass_head",  32'({out_x, out_y, out_z}), 32'h222);
`ifdef XYZ_FIFO_DROP_CNT_EN
        chk("pass_cnt", 32'(drop_cnt), 32'd1);
`endif
        cyc(0, 0, 0, 0, 0, 1);
        chk("clr_ovf", 32'(overflow), 32'd0);
`ifdef XYZ_FIFO_DROP_CNT_EN
        chk("clr_cnt", 32'(drop_cnt), 32'd0);
`endif
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
        chk("pass_empty", 32'(empty), 32'd1);
        want = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h666};
        chk_log("pass_pop");

        // Wrap-around with continuous push/pop
        want.delete();
        for (int i = 0; i < 10; i++) begin
            cyc(1, 4'(i), 4'(i + 3), 4'(15 - i), 1, 0);
            want.push_back({4'(i), 4'(i + 3), 4'(15 - i)});
        end
        cyc(0, 0, 0, 0, 1, 0);
        chk("wrap_ovf",   32'(overflow), 32'd0);
        chk("wrap_empty", 32'(empty), 32'd1);
        chk_log("wrap_pop");

        // Asynchronous reset mid-operation
        cyc(1, 1, 2, 3, 0, 0);
        cyc(1, 4, 5, 6, 0, 0);
        cyc(1, 7, 8, 9, 0, 0);
        in_valid = 1'b0;
        chk("arst_pre", 32'(count), 32'd3);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data",  32'({out_x, out_y, out_z}), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        popped.delete();
        cyc(1, 9, 10, 11, 0, 0);
        cyc(1, 12, 13, 14, 0, 0);
        chk("arst_head", 32'({out_x, out_y, out_z}), 32'h9AB);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        want = '{12'h9AB, 12'hCDE};
        chk_log("arst_pop");

        cyc(0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
